// File: rtl/serial_adder.sv
// Digit-serial adder/subtractor: DIGIT bits per clock through one carry register.
// Valid/ready on both sides; result held in DONE until the consumer accepts it.
module serial_adder #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int K  = WIDTH / DIGIT;
    localparam int CW = (K > 1) ? $clog2(K) : 1;
    localparam int BW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(K - 1);

    if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
        $error("serial_adder: WIDTH >= 2 and DIGIT dividing WIDTH required");
    end

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic             r_cout;
    logic             r_ovf;
    logic [CW-1:0]    r_cnt;

    logic [BW-1:0]    w_base;
    logic [DIGIT-1:0] w_ad;
    logic [DIGIT-1:0] w_bd;
    logic [DIGIT-1:0] w_ds;
    logic             w_dc;
    logic             w_cmsb;
    logic             w_last;

    assign w_base = BW'(r_cnt) * BW'(DIGIT);
    assign w_ad   = r_a[w_base +: DIGIT];
    assign w_bd   = r_b[w_base +: DIGIT];
    assign w_last = (r_cnt == LAST);

    assign {w_dc, w_ds} = {1'b0, w_ad} + {1'b0, w_bd}
                        + {{DIGIT{1'b0}}, r_carry};
    // Carry into the digit's top bit; on the last digit this is bit WIDTH-1.
    assign w_cmsb = w_ad[DIGIT-1] ^ w_bd[DIGIT-1] ^ w_ds[DIGIT-1];

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign sum       = r_sum;
    assign cout      = r_cout;
    assign overflow  = r_ovf;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (in_valid)  w_next = RUN;
            RUN:     if (w_last)    w_next = DONE;
            DONE:    if (out_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a     <= a;
                        r_b     <= sub ? ~b : b;
                        r_carry <= sub ? ~cin : cin;
                        r_cnt   <= '0;
                    end
                end
                RUN: begin
                    r_sum[w_base +: DIGIT] <= w_ds;
                    r_carry <= w_dc;
                    r_cout  <= w_dc;
                    r_ovf   <= w_cmsb ^ w_dc;
                    r_cnt   <= r_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
